wb_port_arbiter: RTL and testbench

- Owns the single register-file write port.
- Shares that port between two sources:
  - the MEM/WB pipeline register outputs (regwrite, memtoreg, ALU result, read data, rd);
  - a long-latency execution unit (LU, e.g. mul/div) that returns results out of band.
- Buffers LU results and gives the pipeline priority. Forces a one-cycle pipeline stall when a buffered LU result has waited too long.
- Sits between MEM_WB, the LU and the register file. Exports a busy-rd mask to the hazard unit.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_lu_fifo.sv | 76 +++++++
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds the FSM encoding, datapath widths and LU buffer entry layout.
package wb_pkg;

  localparam int RF_AW = 5;
  localparam int XLEN  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } lu_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Buffer for out-of-band LU results awaiting the write port.
// Entries can be squashed by a younger pipeline write to the same rd.
module wb_lu_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [RF_AW-1:0] push_rd,
  input  logic [XLEN-1:0]  push_data,
  input  logic             pop,
  input  logic             inv_en,
  input  logic [RF_AW-1:0] inv_rd,
  output lu_entry_t        head,
  output logic             ready,
  output logic             empty,
  output logic             one,
  output logic [XLEN-1:0]  busy_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lu_entry_t         mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  assign head  = mem[rd_ptr];
  assign ready = count != CW'(DEPTH);
  assign empty = count == '0;
  assign one   = count == CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && mem[i].valid && mem[i].rd == inv_rd) begin
          mem[i].valid <= 1'b0;
        end
      end
      // popped slots drop their valid bit so busy_mask sees only live entries
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{valid: 1'b1, rd: push_rd, data: push_data};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid) begin
        busy_mask[mem[i].rd] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority,
// buffered LU results drain in free slots or via a one-cycle forced stall.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pipe_regwrite_i,
  input  logic             pipe_memtoreg_i,
  input  logic [XLEN-1:0]  pipe_aluresult_i,
  input  logic [XLEN-1:0]  pipe_readdata_i,
  input  logic [RF_AW-1:0] pipe_rd_i,
  input  logic             lu_valid_i,
  input  logic [RF_AW-1:0] lu_rd_i,
  input  logic [XLEN-1:0]  lu_data_i,
  output logic             lu_ready_o,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             stall_o,
  output logic [XLEN-1:0]  busy_mask_o
);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       wait_cnt;
  logic [3:0]       wait_nxt;
  lu_entry_t        head;
  logic             ready;
  logic             empty;
  logic             one;
  logic [XLEN-1:0]  busy;
  logic             pw;
  logic             push;
  logic             pop;
  logic             inv_en;
  logic             last;
  logic             we;
  logic             stall;
  logic [RF_AW-1:0] waddr;
  logic [XLEN-1:0]  wdata;
  logic [XLEN-1:0]  pdata;

  assign pw    = pipe_regwrite_i && (pipe_rd_i != '0);
  assign pdata = pipe_memtoreg_i ? pipe_readdata_i : pipe_aluresult_i;

  assign lu_ready_o = ready && !rst_i;
  // rd 0 results are acknowledged but never stored
  assign push = lu_valid_i && lu_ready_o && (lu_rd_i != '0);

  wb_lu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .push_rd  (lu_rd_i),
    .push_data(lu_data_i),
    .pop      (pop),
    .inv_en   (inv_en),
    .inv_rd   (pipe_rd_i),
    .head     (head),
    .ready    (ready),
    .empty    (empty),
    .one      (one),
    .busy_mask(busy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    stall     = 1'b0;
    pop       = 1'b0;
    inv_en    = 1'b0;
    wait_nxt  = wait_cnt;
    state_nxt = state;
    last      = 1'b0;

    if (state == FORCE) begin
      stall = 1'b1;
      pop   = 1'b1;
    end else if (pw) begin
      we     = 1'b1;
      waddr  = pipe_rd_i;
      wdata  = pdata;
      inv_en = 1'b1;
    end else if (state == PEND) begin
      pop = 1'b1;
    end

    if (pop && head.valid) begin
      we    = 1'b1;
      waddr = head.rd;
      wdata = head.data;
    end

    if (state != PEND || pop) begin
      wait_nxt = '0;
    end else begin
      wait_nxt = wait_cnt + 4'd1;
    end

    last = (empty && !push) || (one && pop && !push);

    if (state == PEND && !pop && wait_cnt == 4'(MAX_WAIT - 1)) begin
      state_nxt = FORCE;
      wait_nxt  = '0;
    end else begin
      state_nxt = last ? IDLE : PEND;
    end
  end

  assign rf_we_o     = we && !rst_i;
  assign rf_waddr_o  = rst_i ? '0 : waddr;
  assign rf_wdata_o  = rst_i ? '0 : wdata;
  assign stall_o     = stall && !rst_i;
  assign busy_mask_o = rst_i ? '0 : busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed cycles push expected
// outputs, a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        pipe_regwrite_i;
  logic        pipe_memtoreg_i;
  logic [31:0] pipe_aluresult_i;
  logic [31:0] pipe_readdata_i;
  logic [4:0]  pipe_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic [31:0] busy_mask_o;

  typedef struct {
    int          id;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        ready;
    logic [31:0] busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_id   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DEPTH   (2),
    .MAX_WAIT(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .pipe_regwrite_i (pipe_regwrite_i),
    .pipe_memtoreg_i (pipe_memtoreg_i),
    .pipe_aluresult_i(pipe_aluresult_i),
    .pipe_readdata_i (pipe_readdata_i),
    .pipe_rd_i       (pipe_rd_i),
    .lu_valid_i      (lu_valid_i),
    .lu_rd_i         (lu_rd_i),
    .lu_data_i       (lu_data_i),
    .lu_ready_o      (lu_ready_o),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .stall_o         (stall_o),
    .busy_mask_o     (busy_mask_o)
  );

  task automatic chk(input int id, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cyc%0d %s actual=%h required=%h", id, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "rf_we", 32'(rf_we_o), 32'(e.we));
      chk(e.id, "waddr", 32'(rf_waddr_o), 32'(e.waddr));
      chk(e.id, "wdata", rf_wdata_o, e.wdata);
      chk(e.id, "stall", 32'(stall_o), 32'(e.stall));
      chk(e.id, "ready", 32'(lu_ready_o), 32'(e.ready));
      chk(e.id, "busy", busy_mask_o, e.busy);
    end
  end

  // one clock cycle: drive inputs, queue expected outputs, advance
  task automatic cyc(
    input logic r, input logic rw, input logic mtr, input logic [4:0] prd,
    input logic [31:0] alu, input logic [31:0] rdat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic st, input logic rdy, input logic [31:0] bm);
    exp_t e;
    rst_i            = r;
    pipe_regwrite_i  = rw;
    pipe_memtoreg_i  = mtr;
    pipe_rd_i        = prd;
    pipe_aluresult_i = alu;
    pipe_readdata_i  = rdat;
    lu_valid_i       = lv;
    lu_rd_i          = lrd;
    lu_data_i        = ld;
    e.id = cyc_id;
    e.we = we; e.waddr = wa; e.wdata = wd;
    e.stall = st; e.ready = rdy; e.busy = bm;
    q.push_back(e);
    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  // idle cycle with no requests; expects no write
  task automatic idle(input logic [31:0] bm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, bm);
  endtask

  // pipeline writes x9 <= 0x99 with optional LU request
  task automatic pw9(input logic lv, input logic [4:0] lrd,
                     input logic [31:0] ld, input logic rdy,
                     input logic [31:0] bm);
    cyc(0, 1, 0, 9, 32'h99, 32'h0, lv, lrd, ld,
        1, 9, 32'h99, 0, rdy, bm);
  endtask

  initial begin
    rst_i = 1; pipe_regwrite_i = 0; pipe_memtoreg_i = 0;
    pipe_rd_i = 0; pipe_aluresult_i = 0; pipe_readdata_i = 0;
    lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
    @(posedge clk);
    #1;

    // reset with a pipeline write presented: everything held at zero
    cyc(1, 1, 0, 5, 32'h5, 0, 1, 4, 32'h4, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // pipeline only: memtoreg selects read data
    cyc(0, 1, 1, 5, 32'h1, 32'hDEADBEEF, 0, 0, 0,
        1, 5, 32'hDEADBEEF, 0, 1, 0);
    cyc(0, 1, 0, 6, 32'h11, 32'h22, 0, 0, 0, 1, 6, 32'h11, 0, 1, 0);
    // regwrite to x0 is not a write
    cyc(0, 1, 0, 0, 32'h77, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // free slot: LU result drains the cycle after acceptance
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 1, 32'h80);
    idle(0);

    // LU result to x0 is accepted and dropped
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'hBAD, 0, 0, 0, 0, 1, 0);
    idle(0);

    // starvation: four pipeline wins, then a forced stall writes x3
    pw9(1, 3, 32'h33, 1, 0);
    for (int i = 0; i < 4; i++) pw9(0, 0, 0, 1, 32'h8);
    cyc(0, 1, 0, 9, 32'h99, 0, 0, 0, 0, 1, 3, 32'h33, 1, 1, 32'h8);
    pw9(0, 0, 0, 1, 0);
    idle(0);

    // younger wins: pipeline x10 squashes the buffered LU x10
    cyc(0, 0, 0, 0, 0, 0, 1, 10, 32'h55, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 10, 32'hAA, 0, 0, 0, 0, 1, 10, 32'hAA, 0, 1, 32'h400);
    idle(0);
    idle(0);

    // full buffer backpressure, forced pop, then push+pop together
    pw9(1, 1, 32'h100, 1, 0);
    pw9(1, 2, 32'h200, 1, 32'h2);
    pw9(1, 4, 32'h400, 0, 32'h6);
    pw9(1, 4, 32'h400, 0, 32'h6);
    pw9(1, 4, 32'h400, 0, 32'h6);
    cyc(0, 1, 0, 9, 32'h99, 0, 1, 4, 32'h400,
        1, 1, 32'h100, 1, 0, 32'h6);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 32'h400, 1, 2, 32'h200, 0, 1, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h400, 0, 1, 32'h10);
    idle(0);

    // reset asserted during the stall cycle flushes the buffer
    pw9(1, 3, 32'h33, 1, 0);
    for (int i = 0; i < 4; i++) pw9(0, 0, 0, 1, 32'h8);
    cyc(1, 1, 0, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    idle(0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
